// File: rtl/trigger_conditioner_pkg.sv
// rtl/trigger_conditioner_pkg.sv - shared constants for the trigger conditioner
package trigger_conditioner_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FILTER   = 3'd1;
  localparam logic [2:0] ST_FIRE     = 3'd2;
  localparam logic [2:0] ST_HOLDOFF  = 3'd3;
  localparam logic [2:0] ST_WAIT_LOW = 3'd4;

  localparam logic [1:0] TRIG_SRC_NONE = 2'b00;
  localparam logic [1:0] TRIG_SRC_EXT  = 2'b01;
  localparam logic [1:0] TRIG_SRC_ASIC = 2'b10;
  localparam logic [1:0] TRIG_SRC_ANY  = 2'b11;

  localparam int DEFAULT_PULSE_LEN = 4;

  function automatic logic select_src(input logic [1:0] sel, input logic ext, input logic asic);
    case (sel)
      TRIG_SRC_EXT:  return ext;
      TRIG_SRC_ASIC: return asic;
      TRIG_SRC_ANY:  return ext | asic;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/trigger_conditioner_trig_sync.sv
// rtl/trigger_conditioner_trig_sync.sv - multi-stage async-reset synchroniser
module trig_sync #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// rtl/trigger_conditioner.sv - filtered, vetoed, rate-limited trigger pulse generator
module trigger_conditioner
  import trigger_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = DEFAULT_PULSE_LEN,
  parameter int COUNT_W     = 32,
  parameter int REJECT_W    = 16
) (
  input  logic                Clk,
  input  logic                reset_n,
  input  logic                ExtTrigger,
  input  logic                AsicTrigger,
  input  logic [1:0]          TrigSource,
  input  logic                TrigEnable,
  input  logic [3:0]          MinWidth,
  input  logic [7:0]          HoldoffTime,
  input  logic                Veto,
  input  logic                CounterClear,
  output logic                TriggerOut,
  output logic                TriggerBusy,
  output logic [COUNT_W-1:0]  TriggerCount,
  output logic [REJECT_W-1:0] RejectCount
);

  localparam int PCNT_W = $clog2(PULSE_LEN);

  logic                w_ext_sync;
  logic                w_asic_sync;
  logic                w_src;
  logic                w_qualify;
  logic                w_accept;
  logic                w_reject;
  logic                w_pulse_done;
  logic                w_holdoff_done;
  logic                r_src_q;
  logic [2:0]          r_state;
  logic [3:0]          r_wcnt;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [7:0]          r_hcnt;
  logic                r_trigger_out;
  logic [COUNT_W-1:0]  r_trigger_count;
  logic [REJECT_W-1:0] r_reject_count;

  trig_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .Clk     (Clk),
    .reset_n (reset_n),
    .i_async (ExtTrigger),
    .o_sync  (w_ext_sync)
  );

  trig_sync #(.STAGES(SYNC_STAGES)) u_sync_asic (
    .Clk     (Clk),
    .reset_n (reset_n),
    .i_async (AsicTrigger),
    .o_sync  (w_asic_sync)
  );

  assign w_src = select_src(TrigSource, w_ext_sync, w_asic_sync);

  // Compare with >= so a live change of MinWidth/HoldoffTime mid-count cannot strand the FSM
  always_comb begin
    w_qualify      = (r_state == ST_FILTER) && w_src && TrigEnable && (r_wcnt >= MinWidth);
    w_accept       = w_qualify && !Veto;
    w_reject       = (w_qualify && Veto) || ((r_state == ST_HOLDOFF) && w_src && !r_src_q);
    w_pulse_done   = (r_pcnt == PCNT_W'(PULSE_LEN - 1));
    w_holdoff_done = (({1'b0, r_hcnt} + 9'd1) >= {1'b0, HoldoffTime});
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_src_q       <= 1'b0;
      r_wcnt        <= '0;
      r_pcnt        <= '0;
      r_hcnt        <= '0;
      r_trigger_out <= 1'b0;
    end else begin
      r_src_q <= w_src;
      case (r_state)
        ST_IDLE: begin
          if (TrigEnable && w_src) begin
            r_state <= ST_FILTER;
            r_wcnt  <= '0;
          end
        end
        ST_FILTER: begin
          if (!w_src || !TrigEnable) begin
            r_state <= ST_IDLE;
          end else if (r_wcnt >= MinWidth) begin
            if (Veto) begin
              r_state <= ST_WAIT_LOW;
            end else begin
              r_state       <= ST_FIRE;
              r_pcnt        <= '0;
              r_trigger_out <= 1'b1;
            end
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        ST_FIRE: begin
          if (w_pulse_done) begin
            r_trigger_out <= 1'b0;
            if (HoldoffTime != 8'd0) begin
              r_state <= ST_HOLDOFF;
              r_hcnt  <= '0;
            end else begin
              r_state <= ST_WAIT_LOW;
            end
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (w_holdoff_done) begin
            r_state <= ST_WAIT_LOW;
          end else begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        ST_WAIT_LOW: begin
          if (!w_src) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_trigger_out <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_trigger_count <= '0;
      r_reject_count  <= '0;
    end else if (CounterClear) begin
      r_trigger_count <= '0;
      r_reject_count  <= '0;
    end else begin
      if (w_accept) begin
        r_trigger_count <= r_trigger_count + 1'b1;
      end
      if (w_reject && (r_reject_count != '1)) begin
        r_reject_count <= r_reject_count + 1'b1;
      end
    end
  end

  assign TriggerOut   = r_trigger_out;
  assign TriggerBusy  = (r_state != ST_IDLE);
  assign TriggerCount = r_trigger_count;
  assign RejectCount  = r_reject_count;

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb/tb_trigger_conditioner.sv - directed self-checking bench for trigger_conditioner
module tb_trigger_conditioner;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        ExtTrigger;
  logic        AsicTrigger;
  logic [1:0]  TrigSource;
  logic        TrigEnable;
  logic [3:0]  MinWidth;
  logic [7:0]  HoldoffTime;
  logic        Veto;
  logic        CounterClear;
  logic        TriggerOut;
  logic        TriggerBusy;
  logic [3:0]  TriggerCount;
  logic [15:0] RejectCount;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  logic out_q  = 1'b0;

  trigger_conditioner #(
    .SYNC_STAGES (2),
    .PULSE_LEN   (4),
    .COUNT_W     (4),
    .REJECT_W    (16)
  ) dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .ExtTrigger   (ExtTrigger),
    .AsicTrigger  (AsicTrigger),
    .TrigSource   (TrigSource),
    .TrigEnable   (TrigEnable),
    .MinWidth     (MinWidth),
    .HoldoffTime  (HoldoffTime),
    .Veto         (Veto),
    .CounterClear (CounterClear),
    .TriggerOut   (TriggerOut),
    .TriggerBusy  (TriggerBusy),
    .TriggerCount (TriggerCount),
    .RejectCount  (RejectCount)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (TriggerOut && !out_q) pulses++;
    out_q = TriggerOut;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic pulse_ext(input int n);
    ExtTrigger = 1'b1;
    idle(n);
    ExtTrigger = 1'b0;
  endtask

  task automatic pulse_asic(input int n);
    AsicTrigger = 1'b1;
    idle(n);
    AsicTrigger = 1'b0;
  endtask

  initial begin
    int first;
    int hi;
    int p0;

    reset_n      = 1'b0;
    ExtTrigger   = 1'b0;
    AsicTrigger  = 1'b0;
    TrigSource   = 2'b01;
    TrigEnable   = 1'b1;
    MinWidth     = 4'd2;
    HoldoffTime  = 8'd0;
    Veto         = 1'b0;
    CounterClear = 1'b0;
    idle(3);
    check("rst_out",    32'(TriggerOut),   32'd0);
    check("rst_busy",   32'(TriggerBusy),  32'd0);
    check("rst_tcount", 32'(TriggerCount), 32'd0);
    check("rst_rcount", 32'(RejectCount),  32'd0);
    reset_n = 1'b1;
    idle(2);

    // 1: latency SYNC_STAGES + MinWidth + 2 = 6, width 4
    first = 0;
    hi    = 0;
    ExtTrigger = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge Clk);
      if (TriggerOut) begin
        if (first == 0) first = i;
        hi++;
      end
      if (i == 3) check("t1_busy_filter", 32'(TriggerBusy), 32'd1);
      if (i == 10) ExtTrigger = 1'b0;
    end
    idle(4);
    check("t1_latency", 32'(first), 32'd6);
    check("t1_width",   32'(hi),    32'd4);
    check("t1_tcount",  32'(TriggerCount), 32'd1);
    check("t1_rcount",  32'(RejectCount),  32'd0);
    check("t1_idle",    32'(TriggerBusy),  32'd0);

    // 2: glitch shorter than the filter
    MinWidth = 4'd3;
    p0 = pulses;
    pulse_ext(2);
    idle(8);
    check("t2_pulses", 32'(pulses - p0),   32'd0);
    check("t2_tcount", 32'(TriggerCount), 32'd1);
    check("t2_rcount", 32'(RejectCount),  32'd0);
    check("t2_idle",   32'(TriggerBusy),  32'd0);

    // 3: holdoff 20; 2nd pulse lands in holdoff, 3rd well after it
    MinWidth    = 4'd0;
    HoldoffTime = 8'd20;
    p0 = pulses;
    pulse_ext(3);
    idle(7);
    pulse_ext(3);
    idle(27);
    pulse_ext(3);
    idle(40);
    check("t3_pulses", 32'(pulses - p0),   32'd2);
    check("t3_tcount", 32'(TriggerCount), 32'd3);
    check("t3_rcount", 32'(RejectCount),  32'd1);

    // 4: veto during qualification, source held high
    HoldoffTime = 8'd0;
    MinWidth    = 4'd1;
    Veto        = 1'b1;
    p0 = pulses;
    ExtTrigger  = 1'b1;
    idle(50);
    check("t4_busy_waitlow", 32'(TriggerBusy), 32'd1);
    ExtTrigger = 1'b0;
    idle(6);
    Veto = 1'b0;
    check("t4_pulses", 32'(pulses - p0),   32'd0);
    check("t4_tcount", 32'(TriggerCount), 32'd3);
    check("t4_rcount", 32'(RejectCount),  32'd2);
    check("t4_idle",   32'(TriggerBusy),  32'd0);

    // 5: overlapping sources on ANY -> one pulse; NONE -> nothing; ASIC alone -> one
    TrigSource = 2'b11;
    p0 = pulses;
    ExtTrigger = 1'b1;
    idle(4);
    AsicTrigger = 1'b1;
    idle(4);
    ExtTrigger = 1'b0;
    idle(6);
    AsicTrigger = 1'b0;
    idle(8);
    check("t5_any_pulses", 32'(pulses - p0),   32'd1);
    check("t5_any_tcount", 32'(TriggerCount), 32'd4);
    TrigSource = 2'b00;
    p0 = pulses;
    pulse_ext(5);
    idle(5);
    pulse_asic(5);
    idle(8);
    check("t5_none_pulses", 32'(pulses - p0),   32'd0);
    check("t5_none_tcount", 32'(TriggerCount), 32'd4);
    TrigSource = 2'b10;
    pulse_asic(5);
    idle(10);
    check("t5_asic_tcount", 32'(TriggerCount), 32'd5);

    // 6: clear, wrap of the 4-bit counter, clear vs accept, reset mid-pulse
    TrigSource   = 2'b01;
    CounterClear = 1'b1;
    idle(1);
    CounterClear = 1'b0;
    check("t6_clr_tcount", 32'(TriggerCount), 32'd0);
    check("t6_clr_rcount", 32'(RejectCount),  32'd0);
    for (int k = 0; k < 15; k++) begin
      pulse_ext(3);
      idle(10);
    end
    check("t6_allones", 32'(TriggerCount), 32'd15);
    pulse_ext(3);
    idle(10);
    check("t6_wrap", 32'(TriggerCount), 32'd0);
    pulse_ext(3);
    idle(10);
    check("t6_one", 32'(TriggerCount), 32'd1);

    // accept occurs at the 5th edge after the rise (MinWidth=1)
    ExtTrigger = 1'b1;
    idle(3);
    ExtTrigger = 1'b0;
    idle(1);
    CounterClear = 1'b1;
    idle(1);
    CounterClear = 1'b0;
    check("t6_clr_prio", 32'(TriggerCount), 32'd0);
    check("t6_firing",   32'(TriggerOut),   32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_out",  32'(TriggerOut),  32'd0);
    check("t6_rst_busy", 32'(TriggerBusy), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(3);
    check("t6_post_rst_out", 32'(TriggerOut), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
